bios_loader: RTL and testbench
==============================

BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 SHALL have parameter SRC_ADDR, default 24'h10_0000, meaning flash start address of the BIOS image (NEXTOR followed by FM-BIOS).
REQ-002 SHALL have parameter DST_ADDR, default 24'h70_0000, meaning SD-RAM start address of the BIOS image.
REQ-003 SHALL have parameter SIZE, default 24'h02_4000, meaning number of bytes to copy (NEXTOR 128KB plus FM-BIOS 16KB).
REQ-004 SHALL have port CLK  input  1  sole clock; all sequential logic on its rising edge.
REQ-005 SHALL have port RESET_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port RELOAD  input  1  one-cycle pulse requesting a new copy.
REQ-007 SHALL have port FLASH_REQ  output  1  flash read request.
REQ-008 SHALL have port FLASH_ADDR  output  24  flash byte address.
REQ-009 SHALL have port FLASH_ACK  input  1  flash read complete; FLASH_DATA is valid in the same cycle.
REQ-010 SHALL have port FLASH_DATA  input  8  flash read data.
REQ-011 SHALL have port RAM_REQ  output  1  SD-RAM write request.
REQ-012 SHALL have port RAM_ADDR  output  24  SD-RAM byte address.
REQ-013 SHALL have port RAM_DATA  output  8  SD-RAM write data.
REQ-014 SHALL have port RAM_ACK  input  1  SD-RAM write accepted.
REQ-015 SHALL have port BUSY  output  1  high while the copy is in progress; MSX bus holds off BIOS slots.
REQ-016 SHALL have port DONE  output  1  high once a copy has completed; stays high until the next copy starts.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, FINISH.
REQ-018 In IDLE, on the first cycle after reset release, or when RELOAD is sampled high, SHALL load byte counter CNT=0, clear DONE, set BUSY, and go to READ; if SIZE==0, SHALL go directly to FINISH.
REQ-019 In READ, SHALL drive FLASH_REQ=1 and FLASH_ADDR=SRC_ADDR+CNT (24-bit, wraps modulo 2^24).
REQ-020 On FLASH_ACK=1 in READ, SHALL latch FLASH_DATA into RAM_DATA and go to WRITE; FLASH_REQ SHALL be 0 from the next cycle.
REQ-021 In WRITE, SHALL drive RAM_REQ=1 and RAM_ADDR=DST_ADDR+CNT, holding RAM_ADDR and RAM_DATA stable until RAM_ACK.
REQ-022 On RAM_ACK=1 in WRITE, SHALL increment CNT; if the new CNT==SIZE, SHALL go to FINISH, else to READ. RAM_REQ SHALL be 0 from the next cycle.
REQ-023 Each request SHALL stay asserted until its ACK is sampled, then drop for at least one cycle; the block SHALL NOT assert FLASH_REQ and RAM_REQ together.
REQ-024 An ACK arriving while the matching REQ is low SHALL be ignored.
REQ-025 In FINISH, SHALL clear BUSY, set DONE, and return to IDLE in the next cycle.
REQ-026 RELOAD while BUSY=1 SHALL be ignored, with no restart and no queuing.
REQ-027 Per-byte latency SHALL be 1 + flash-ACK wait + 1 + RAM-ACK wait cycles; with ACK returned in the same cycle as REQ, each byte takes 2 cycles.
REQ-028 CNT SHALL be 24 bits and SHALL never exceed SIZE.

Reset
REQ-029 RESET_n low SHALL asynchronously force IDLE with CNT=0, FLASH_REQ=0, RAM_REQ=0, FLASH_ADDR=0, RAM_ADDR=0, RAM_DATA=0, BUSY=0, DONE=0.
REQ-030 Reset asserted mid-copy SHALL abandon the copy, with requests low in the same cycle; after release, the copy SHALL restart from CNT=0.
REQ-031 The automatic start SHALL occur exactly once per reset release.

Verification
REQ-032 Reset release, SIZE=4, zero-wait ACKs -> flash addresses 10_0000..10_0003 and RAM addresses 70_0000..70_0003 with matching data; DONE=1 after 8 transfer cycles plus FINISH.
REQ-033 FLASH_ACK delayed 3 cycles and RAM_ACK delayed 5 cycles -> REQ held and address/data stable throughout; no overlap of FLASH_REQ and RAM_REQ.
REQ-034 Reset asserted at CNT=2 -> outputs zero immediately; after release, the first FLASH_ADDR is 10_0000 again.
REQ-035 RELOAD pulse while BUSY -> no effect; RELOAD pulse after DONE -> DONE clears, a full second copy runs, and DONE sets again.
REQ-036 SIZE=0 -> no requests issued; BUSY low; DONE=1 within 2 cycles of reset release.
REQ-037 Spurious RAM_ACK during READ -> ignored; CNT and addresses unchanged.

Source files
------------

// File: rtl/bios_loader.sv
// Copies the BIOS image from flash into SD-RAM once after reset
// and again on every RELOAD pulse while idle.
module bios_loader #(
   parameter logic [23:0] SRC_ADDR = 24'h10_0000,
   parameter logic [23:0] DST_ADDR = 24'h70_0000,
   parameter logic [23:0] SIZE     = 24'h02_4000
) (
   input  logic        CLK,
   input  logic        RESET_n,
   input  logic        RELOAD,
   output logic        FLASH_REQ,
   output logic [23:0] FLASH_ADDR,
   input  logic        FLASH_ACK,
   input  logic [7:0]  FLASH_DATA,
   output logic        RAM_REQ,
   output logic [23:0] RAM_ADDR,
   output logic [7:0]  RAM_DATA,
   input  logic        RAM_ACK,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FINISH
   } state_t;

   state_t      state, state_n;
   logic [23:0] cnt, cnt_n, cnt_inc;
   logic        armed, armed_n;
   logic        flash_req_n, ram_req_n;
   logic        busy_n, done_n;
   logic [23:0] flash_addr_n, ram_addr_n;
   logic [7:0]  ram_data_n;

   assign cnt_inc = cnt + 24'd1;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= IDLE;
         cnt        <= '0;
         armed      <= 1'b1;
         FLASH_REQ  <= 1'b0;
         FLASH_ADDR <= '0;
         RAM_REQ    <= 1'b0;
         RAM_ADDR   <= '0;
         RAM_DATA   <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         armed      <= armed_n;
         FLASH_REQ  <= flash_req_n;
         FLASH_ADDR <= flash_addr_n;
         RAM_REQ    <= ram_req_n;
         RAM_ADDR   <= ram_addr_n;
         RAM_DATA   <= ram_data_n;
         BUSY       <= busy_n;
         DONE       <= done_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      armed_n      = armed;
      flash_req_n  = FLASH_REQ;
      flash_addr_n = FLASH_ADDR;
      ram_req_n    = RAM_REQ;
      ram_addr_n   = RAM_ADDR;
      ram_data_n   = RAM_DATA;
      busy_n       = BUSY;
      done_n       = DONE;
      unique case (state)
         IDLE: begin
            // armed gives the single automatic start after reset
            if (armed || RELOAD) begin
               armed_n = 1'b0;
               cnt_n   = '0;
               done_n  = 1'b0;
               if (SIZE == 24'd0) begin
                  state_n = FINISH;
               end else begin
                  busy_n       = 1'b1;
                  flash_req_n  = 1'b1;
                  flash_addr_n = SRC_ADDR;
                  state_n      = READ;
               end
            end
         end
         READ: begin
            if (FLASH_ACK && FLASH_REQ) begin
               flash_req_n = 1'b0;
               ram_data_n  = FLASH_DATA;
               ram_req_n   = 1'b1;
               ram_addr_n  = DST_ADDR + cnt;
               state_n     = WRITE;
            end
         end
         WRITE: begin
            if (RAM_ACK && RAM_REQ) begin
               ram_req_n = 1'b0;
               cnt_n     = cnt_inc;
               if (cnt_inc == SIZE) begin
                  state_n = FINISH;
               end else begin
                  flash_req_n  = 1'b1;
                  flash_addr_n = SRC_ADDR + cnt_inc;
                  state_n      = READ;
               end
            end
         end
         FINISH: begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: flash/RAM responders with programmable
// ACK delays and a queue of expected RAM writes.
module tb_bios_loader;

   localparam logic [23:0] SRC = 24'h10_0000;
   localparam logic [23:0] DST = 24'h70_0000;

   logic        CLK = 1'b0;
   logic        RESET_n = 1'b0;
   logic        RELOAD = 1'b0;
   logic        FLASH_REQ;
   logic [23:0] FLASH_ADDR;
   logic        FLASH_ACK = 1'b0;
   logic [7:0]  FLASH_DATA = 8'h00;
   logic        RAM_REQ;
   logic [23:0] RAM_ADDR;
   logic [7:0]  RAM_DATA;
   logic        RAM_ACK = 1'b0;
   logic        BUSY;
   logic        DONE;

   logic        z_freq, z_rreq, z_busy, z_done;
   logic [23:0] z_faddr, z_raddr;
   logic [7:0]  z_rdata;
   logic        z_reload = 1'b0;
   logic        z_ack = 1'b0;
   logic [7:0]  z_fdata = 8'h00;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   bios_loader #(
      .SRC_ADDR(SRC),
      .DST_ADDR(DST),
      .SIZE(24'd4)
   ) dut (
      .CLK(CLK),
      .RESET_n(RESET_n),
      .RELOAD(RELOAD),
      .FLASH_REQ(FLASH_REQ),
      .FLASH_ADDR(FLASH_ADDR),
      .FLASH_ACK(FLASH_ACK),
      .FLASH_DATA(FLASH_DATA),
      .RAM_REQ(RAM_REQ),
      .RAM_ADDR(RAM_ADDR),
      .RAM_DATA(RAM_DATA),
      .RAM_ACK(RAM_ACK),
      .BUSY(BUSY),
      .DONE(DONE)
   );

   bios_loader #(
      .SRC_ADDR(SRC),
      .DST_ADDR(DST),
      .SIZE(24'd0)
   ) dut0 (
      .CLK(CLK),
      .RESET_n(RESET_n),
      .RELOAD(z_reload),
      .FLASH_REQ(z_freq),
      .FLASH_ADDR(z_faddr),
      .FLASH_ACK(z_ack),
      .FLASH_DATA(z_fdata),
      .RAM_REQ(z_rreq),
      .RAM_ADDR(z_raddr),
      .RAM_DATA(z_rdata),
      .RAM_ACK(z_ack),
      .BUSY(z_busy),
      .DONE(z_done)
   );

   // zero-size instance: latency to DONE and absence of activity
   bit z_bad = 0;
   bit z_got = 0;
   int z_n = 0;
   int z_lat = 0;
   always @(negedge CLK) begin
      if (z_freq || z_rreq || z_busy) z_bad = 1;
      if (!RESET_n) begin
         z_n = 0;
         z_got = 0;
      end else if (!z_got) begin
         z_n++;
         if (z_done) begin
            z_got = 1;
            z_lat = z_n;
         end
      end
   end

   typedef struct {
      logic [23:0] a;
      logic [7:0]  d;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int fw;
      int rw;
      bit spur;
      bit relmid;
      int busy_cyc;
   } vec_t;

   task automatic chk(input string nm, input bit ok,
                      input longint act, input longint req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] pat(input logic [23:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   task automatic run(input int fw, input int rw, input bit spur,
                      input bit relmid, input bit dorel,
                      input int rst_at, input int busy_exp);
      int fcnt = 0, rcnt = 0, k = 0, bcyc = 0;
      bit seen = 0, fin = 0, unst = 0, ovl = 0, mid = 0;
      bit aborted = 0, idle_bad = 0;
      logic [23:0] fa_h = '0, ra_h = '0;
      logic [7:0]  rd_h = '0;
      exp_t e;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         RELOAD = (dorel && i == 0);
         FLASH_ACK = 1'b0;
         RAM_ACK = 1'b0;
         FLASH_DATA = 8'($urandom);
         if (BUSY) begin
            seen = 1;
            bcyc++;
         end
         if (seen && DONE && !BUSY) begin
            fin = 1;
            break;
         end
         if (FLASH_REQ && RAM_REQ) ovl = 1;
         if (relmid && !mid && k == 2 && BUSY) begin
            RELOAD = 1'b1;
            mid = 1;
         end
         if (rst_at >= 0 && k == rst_at && FLASH_REQ && fcnt == 0) begin
            RESET_n = 1'b0;
            #1;
            chk("rst_outputs",
                {FLASH_REQ, RAM_REQ, BUSY, DONE} == 4'b0 &&
                FLASH_ADDR == 0 && RAM_ADDR == 0 && RAM_DATA == 0,
                {FLASH_REQ, RAM_REQ, BUSY, DONE, FLASH_ADDR,
                 RAM_ADDR, RAM_DATA}, 0);
            sb.delete();
            aborted = 1;
            break;
         end
         if (FLASH_REQ) begin
            if (fcnt == 0) begin
               fa_h = FLASH_ADDR;
               chk("flash_addr", FLASH_ADDR == SRC + 24'(k),
                   FLASH_ADDR, SRC + 24'(k));
            end else if (FLASH_ADDR != fa_h) begin
               unst = 1;
            end
            if (fcnt == fw) begin
               FLASH_ACK = 1'b1;
               FLASH_DATA = pat(FLASH_ADDR);
               e.a = DST + 24'(k);
               e.d = pat(FLASH_ADDR);
               sb.push_back(e);
               fcnt = 0;
            end else begin
               fcnt++;
            end
            if (spur) RAM_ACK = 1'b1;
         end
         if (RAM_REQ) begin
            if (rcnt == 0) begin
               ra_h = RAM_ADDR;
               rd_h = RAM_DATA;
            end else if (RAM_ADDR != ra_h || RAM_DATA != rd_h) begin
               unst = 1;
            end
            if (rcnt == rw) begin
               RAM_ACK = 1'b1;
               if (sb.size() == 0) begin
                  chk("sb_empty", 0, 0, 1);
               end else begin
                  e = sb.pop_front();
                  chk("ram_write",
                      RAM_ADDR == e.a && RAM_DATA == e.d,
                      {RAM_ADDR, RAM_DATA}, {e.a, e.d});
               end
               k++;
               rcnt = 0;
            end else begin
               rcnt++;
            end
         end
      end
      RELOAD = 1'b0;
      FLASH_ACK = 1'b0;
      RAM_ACK = 1'b0;
      if (aborted) return;
      chk("finished", fin, fin, 1);
      chk("bytes", k == 4, k, 4);
      chk("busy_cycles", bcyc == busy_exp, bcyc, busy_exp);
      chk("stable", !unst, unst, 0);
      chk("no_overlap", !ovl, ovl, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (FLASH_REQ || RAM_REQ || BUSY || !DONE) idle_bad = 1;
      end
      chk("idle_after_done", !idle_bad, idle_bad, 0);
   endtask

   vec_t vt[4];

   initial begin
      vt[0] = '{fw: 3, rw: 5, spur: 0, relmid: 0, busy_cyc: 41};
      vt[1] = '{fw: 1, rw: 0, spur: 1, relmid: 0, busy_cyc: 13};
      vt[2] = '{fw: 0, rw: 2, spur: 0, relmid: 1, busy_cyc: 17};
      vt[3] = '{fw: 2, rw: 1, spur: 1, relmid: 1, busy_cyc: 21};

      repeat (3) @(negedge CLK);
      #1;
      chk("reset_state",
          {FLASH_REQ, RAM_REQ, BUSY, DONE} == 4'b0 &&
          FLASH_ADDR == 0 && RAM_ADDR == 0 && RAM_DATA == 0,
          {FLASH_REQ, RAM_REQ, BUSY, DONE}, 0);
      #1 RESET_n = 1'b1;

      // automatic copy after reset, zero-wait
      run(0, 0, 0, 0, 0, -1, 9);
      chk("size0_latency", z_got && z_lat <= 2, z_lat, 2);

      for (int i = 0; i < 4; i++)
         run(vt[i].fw, vt[i].rw, vt[i].spur, vt[i].relmid,
             1, -1, vt[i].busy_cyc);

      // reset in the middle of a copy, then automatic restart
      run(0, 0, 0, 0, 1, 2, 0);
      @(negedge CLK);
      #2 RESET_n = 1'b1;
      run(0, 0, 0, 0, 0, -1, 9);

      // reload without reset after a completed copy
      run(0, 0, 0, 0, 1, -1, 9);

      chk("size0_quiet", !z_bad, z_bad, 0);
      chk("size0_done", z_done && z_got && z_lat <= 2, z_lat, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
